// File: rtl/cache_system.sv
// Read-only two-level cache model in front of a 2048-word constant memory image.
// cache_level holds one level's valid/tag/data/age arrays and does lookup, fill and LRU touch.
module cache_level #(
  parameter int WAYS  = 2,
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        update,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] hit_data
);

  localparam int SETS = LINES / WAYS;
  localparam int IW   = $clog2(SETS);
  localparam int TW   = 11 - IW;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [1:0] MAX_AGE = 2'(WAYS - 1);

  logic          line_valid [SETS][WAYS];
  logic [TW-1:0] line_tag   [SETS][WAYS];
  logic [31:0]   line_data  [SETS][WAYS];
  logic [1:0]    line_age   [SETS][WAYS];

  logic [IW-1:0] set_idx;
  logic [TW-1:0] tag_in;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim_way;
  logic [WW-1:0] touch_way;
  logic [1:0]    touch_prev;
  logic          inv_found;
  logic [1:0]    best_age;

  assign set_idx = addr[IW-1:0];
  assign tag_in  = addr[10:IW];

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && line_valid[set_idx][w] && line_tag[set_idx][w] == tag_in) begin
        hit      = 1'b1;
        hit_way  = WW'(w);
        hit_data = line_data[set_idx][w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest way (ages form a permutation once the set is full).
  always_comb begin
    victim_way = '0;
    inv_found  = 1'b0;
    best_age   = line_age[set_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !line_valid[set_idx][w]) begin
        inv_found  = 1'b1;
        victim_way = WW'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (line_age[set_idx][w] > best_age) begin
          best_age   = line_age[set_idx][w];
          victim_way = WW'(w);
        end
      end
    end
  end

  // A fill into an empty way ages every other way, so the new line becomes MRU and the set stays LRU-ordered.
  always_comb begin
    touch_way  = hit ? hit_way : victim_way;
    touch_prev = MAX_AGE;
    if (hit || line_valid[set_idx][victim_way]) begin
      touch_prev = line_age[set_idx][touch_way];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          line_valid[s][w] <= 1'b0;
          line_age[s][w]   <= 2'd0;
        end
      end
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == touch_way) begin
          line_age[set_idx][w] <= 2'd0;
        end else if (line_age[set_idx][w] < touch_prev) begin
          line_age[set_idx][w] <= line_age[set_idx][w] + 2'd1;
        end
      end
      if (!hit) begin
        line_valid[set_idx][victim_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (update && !hit) begin
      line_tag[set_idx][victim_way]  <= tag_in;
      line_data[set_idx][victim_way] <= fill_data;
    end
  end

endmodule

module cache_system #(
  parameter int WAYS     = 2,
  parameter int L1_LINES = 16,
  parameter int L2_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        read,
  output logic [31:0] read_data,
  output logic        l1_hit,
  output logic        l2_hit
);

  logic [31:0] mem_word;
  logic        l1_lookup_hit;
  logic [31:0] l1_lookup_data;
  logic        l2_lookup_hit;
  logic [31:0] l2_lookup_data;
  logic [31:0] l1_fill;
  logic        l2_update;

  assign mem_word  = 32'hC0DE0000 | {21'd0, addr};
  assign l1_fill   = l2_lookup_hit ? l2_lookup_data : mem_word;
  assign l2_update = read && !l1_lookup_hit;

  cache_level #(.WAYS(WAYS), .LINES(L1_LINES)) u_l1 (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .update    (read),
    .fill_data (l1_fill),
    .hit       (l1_lookup_hit),
    .hit_data  (l1_lookup_data)
  );

  cache_level #(.WAYS(WAYS), .LINES(L2_LINES)) u_l2 (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .update    (l2_update),
    .fill_data (mem_word),
    .hit       (l2_lookup_hit),
    .hit_data  (l2_lookup_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= 32'd0;
      l1_hit    <= 1'b0;
      l2_hit    <= 1'b0;
    end else if (read) begin
      l1_hit <= l1_lookup_hit;
      l2_hit <= !l1_lookup_hit && l2_lookup_hit;
      if (l1_lookup_hit) begin
        read_data <= l1_lookup_data;
      end else if (l2_lookup_hit) begin
        read_data <= l2_lookup_data;
      end else begin
        read_data <= mem_word;
      end
    end
  end

endmodule

module cache_system_direct (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        read,
  output logic [31:0] read_data,
  output logic        l1_hit,
  output logic        l2_hit
);
  cache_system #(.WAYS(1)) u_cache (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(read_data), .l1_hit(l1_hit), .l2_hit(l2_hit)
  );
endmodule

module cache_system_2way (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        read,
  output logic [31:0] read_data,
  output logic        l1_hit,
  output logic        l2_hit
);
  cache_system #(.WAYS(2)) u_cache (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(read_data), .l1_hit(l1_hit), .l2_hit(l2_hit)
  );
endmodule

module cache_system_4way (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        read,
  output logic [31:0] read_data,
  output logic        l1_hit,
  output logic        l2_hit
);
  cache_system #(.WAYS(4)) u_cache (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(read_data), .l1_hit(l1_hit), .l2_hit(l2_hit)
  );
endmodule

// File: tb/tb_cache_system.sv
// Drives direct-mapped, 2-way and 4-way cache_system instances with one shared stream
// and compares each against a per-set recency-list model of a true-LRU two-level cache.
module tb_cache_system;

  logic            clk = 1'b0;
  logic            rst;
  logic [10:0]     addr;
  logic            read;
  logic [2:0][31:0] rdata;
  logic [2:0]      l1h;
  logic [2:0]      l2h;

  int assertions = 0;
  int failures   = 0;

  int          q1 [3][16][$];
  int          q2 [3][64][$];
  logic [31:0] exp_rd [3];
  logic        exp_l1 [3];
  logic        exp_l2 [3];

  always #5 clk = ~clk;

  cache_system #(.WAYS(1)) u_direct (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rdata[0]), .l1_hit(l1h[0]), .l2_hit(l2h[0])
  );
  cache_system #(.WAYS(2)) u_2way (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rdata[1]), .l1_hit(l1h[1]), .l2_hit(l2h[1])
  );
  cache_system #(.WAYS(4)) u_4way (
    .clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rdata[2]), .l1_hit(l1h[2]), .l2_hit(l2h[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 16; s++) q1[i][s].delete();
      for (int s = 0; s < 64; s++) q2[i][s].delete();
      exp_rd[i] = 32'd0;
      exp_l1[i] = 1'b0;
      exp_l2[i] = 1'b0;
    end
  endtask

  // Each set is an MRU-first list of resident addresses; a full list drops its tail on a fill.
  task automatic model_read(input int a);
    for (int i = 0; i < 3; i++) begin
      int ways;
      int s1;
      int s2;
      int idx;
      ways = (i == 0) ? 1 : (i == 1) ? 2 : 4;
      s1 = a % (16 / ways);
      s2 = a % (64 / ways);
      exp_rd[i] = 32'hC0DE0000 | 32'(a);
      exp_l1[i] = 1'b0;
      exp_l2[i] = 1'b0;
      idx = -1;
      for (int k = 0; k < q1[i][s1].size(); k++) if (q1[i][s1][k] == a) idx = k;
      if (idx >= 0) begin
        exp_l1[i] = 1'b1;
        q1[i][s1].delete(idx);
        q1[i][s1].push_front(a);
      end else begin
        idx = -1;
        for (int k = 0; k < q2[i][s2].size(); k++) if (q2[i][s2][k] == a) idx = k;
        if (idx >= 0) begin
          exp_l2[i] = 1'b1;
          q2[i][s2].delete(idx);
        end else if (q2[i][s2].size() == ways) begin
          void'(q2[i][s2].pop_back());
        end
        q2[i][s2].push_front(a);
        if (q1[i][s1].size() == ways) void'(q1[i][s1].pop_back());
        q1[i][s1].push_front(a);
      end
    end
  endtask

  task automatic verify_all(input string ctx);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s data w%0d", ctx, i), rdata[i], exp_rd[i]);
      checkOutput($sformatf("%s l1_hit w%0d", ctx, i), 32'(l1h[i]), 32'(exp_l1[i]));
      checkOutput($sformatf("%s l2_hit w%0d", ctx, i), 32'(l2h[i]), 32'(exp_l2[i]));
    end
  endtask

  task automatic applyStimulus(input int a, input logic rd);
    @(negedge clk);
    addr = 11'(a);
    read = rd;
    if (rd) model_read(a);
    @(posedge clk);
    #1;
    verify_all($sformatf("%s %h", rd ? "read" : "idle", a));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    read = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    verify_all("reset");
    #1 rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    read = 1'b0;
    addr = '0;
    model_reset();
    #3;
    verify_all("por");
    #9 rst = 1'b1;

    applyStimulus(11'h005, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("first read data", rdata[i], 32'hC0DE0005);
      checkOutput("first read l1", 32'(l1h[i]), 32'd0);
    end
    applyStimulus(11'h005, 1'b1);
    checkOutput("reread l1 w4", 32'(l1h[2]), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(11'h005, 1'b0);
    applyStimulus(11'h005, 1'b1);

    reset_pulse();
    applyStimulus(11'h005, 1'b1);
    applyStimulus(11'h015, 1'b1);
    applyStimulus(11'h005, 1'b1);
    checkOutput("conflict l1 w1", 32'(l1h[0]), 32'd0);
    checkOutput("conflict l2 w1", 32'(l2h[0]), 32'd1);
    checkOutput("conflict data w1", rdata[0], 32'hC0DE0005);
    checkOutput("conflict l1 w2", 32'(l1h[1]), 32'd1);
    checkOutput("conflict l1 w4", 32'(l1h[2]), 32'd1);

    reset_pulse();
    foreach (q1[0][0][k]) begin end
    applyStimulus(11'h001, 1'b1);
    applyStimulus(11'h005, 1'b1);
    applyStimulus(11'h009, 1'b1);
    applyStimulus(11'h00D, 1'b1);
    applyStimulus(11'h001, 1'b1);
    applyStimulus(11'h011, 1'b1);
    applyStimulus(11'h001, 1'b1);
    checkOutput("lru keep l1 w4", 32'(l1h[2]), 32'd1);
    applyStimulus(11'h005, 1'b1);
    checkOutput("lru evict l1 w4", 32'(l1h[2]), 32'd0);
    checkOutput("lru evict l2 w4", 32'(l2h[2]), 32'd1);
    checkOutput("lru evict data w4", rdata[2], 32'hC0DE0005);

    applyStimulus(11'h005, 1'b1);
    reset_pulse();
    applyStimulus(11'h005, 1'b1);
    checkOutput("post reset l2 w2", 32'(l2h[1]), 32'd0);

    for (int n = 0; n < 800; n++) begin
      int r;
      int a;
      r = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2047));
      if (r < 2) reset_pulse();
      else if (r < 20) applyStimulus(a, 1'b0);
      else applyStimulus(a, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/cache_system.md
# cache_system

Read-only two-level (L1/L2) cache model in front of a 2048-word main-memory image, with the associativity set by a parameter. It is used as a performance-evaluation block: a bench issues single-word reads and counts the L1 and L2 hit flags. Instances with `WAYS=1`, `2` and `4` provide the direct-mapped, 2-way and 4-way variants (`cache_system_direct`, `cache_system_2way` and `cache_system_4way` wrappers).

## Interface
- `WAYS`, default 2: associativity of both L1 and L2; legal values are 1, 2 and 4.
- `L1_LINES`, default 16: total L1 lines, one 32-bit word per line.
- `L2_LINES`, default 64: total L2 lines, one 32-bit word per line.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `addr`  input  11  word address, 0x000–0x7FF.
- `read`  input  1  read request, sampled on the rising edge.
- `read_data`  output  32  data of the last completed access (registered).
- `l1_hit`  output  1  last access hit in L1 (registered).
- `l2_hit`  output  1  last access missed L1 and hit L2 (registered).

## Operation
- **Main memory:** internal read-only array of 2048 words, `mem[a] = 32'hC0DE0000 | a`. It is never written.
- **L1 geometry:**
  - Sets: `S1 = L1_LINES/WAYS`.
  - Index: `addr[log2(S1)-1:0]`.
  - Tag: remaining upper address bits.
- **L2 geometry:** same split, using `S2 = L2_LINES/WAYS`.
- **Per-line state:** valid bit, tag, 32-bit data.
- **Per-way state:** 2-bit age counter for LRU ordering (unused when `WAYS=1`).
- **Access:** on a rising edge with `read=1`, both levels are looked up combinationally against the current state.
  - **L1 hit:** `l1_hit=1`, `l2_hit=0`, `read_data` = L1 word. L1 LRU is touched; L2 is unchanged.
  - **L1 miss, L2 hit:** `l1_hit=0`, `l2_hit=1`, `read_data` = L2 word. The word is filled into the L1 victim way; the L2 way and the L1 filled way are touched.
  - **Both miss:** `l1_hit=0`, `l2_hit=0`, `read_data = mem[addr]`. The word is filled into both the L1 and L2 victim ways, and both are touched.
- **Victim selection:**
  - Lowest-numbered invalid way in the set.
  - Otherwise the way with the maximum age.
  - With `WAYS=1`, the single line is always the victim.
- **Touch (LRU update):** the accessed way's age is set to 0. Every other way in the set whose age is below the accessed way's previous age is incremented by 1. This keeps the ages in each set a permutation.
- **Inclusion:** not enforced. An L2 eviction does not invalidate L1.
- **No read:** a rising edge with `read=0` changes no state, and all outputs hold their values.
- **Reset:**
  - All valid bits and ages are cleared to 0.
  - `read_data=0`, `l1_hit=0`, `l2_hit=0`.
  - Outputs reset immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: outputs reflect the access sampled at edge N and are valid immediately after edge N.
- Outputs are held until the next edge with `read=1`.
- Back-to-back reads on consecutive edges are allowed. Each read sees the state left by the previous read, including its fills.
- `l1_hit` and `l2_hit` are never both 1.
- Asserting reset during a stream discards all cache contents; the next read is a miss in both levels.
- Release reset away from a rising clock edge. The first access is the first edge after release with `read=1`.

## Test plan
- **Reset:** hold `rst=0` → `read_data=0`, `l1_hit=0`, `l2_hit=0`. Release reset, read 0x005 → `l1_hit=0`, `l2_hit=0`, `read_data=32'hC0DE0005`.
- **L1 hit:** read 0x005 twice → second access gives `l1_hit=1`, `l2_hit=0`, `read_data=32'hC0DE0005`.
- **Conflict:** read 0x005, 0x015, 0x005.
  - `WAYS=1`: third access gives `l1_hit=0`, `l2_hit=1`, `read_data=32'hC0DE0005`.
  - `WAYS=2` and `WAYS=4`: third access gives `l1_hit=1`.
- **LRU, `WAYS=4`:** read 0x001, 0x005, 0x009, 0x00D, 0x001, 0x011, then 0x001 and 0x005.
  - 0x001 → `l1_hit=1`.
  - 0x005 → `l1_hit=0`, `l2_hit=1`, `read_data=32'hC0DE0005`.
- **Hold:** after any access, drive 3 edges with `read=0` → outputs unchanged. A following re-read of the same address gives `l1_hit=1`.
- **Mid-stream reset:** read 0x005, pulse `rst=0` → outputs go to 0 immediately. Read 0x005 again → `l1_hit=0`, `l2_hit=0`, `read_data=32'hC0DE0005`.
